// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if
//   Shadow-load bus between the datapath (master) and the scan controller
//   (slave).
//   value   [15:0]  hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//   dp      [3:0]   decimal point per digit, 1 = lit
//   en      [3:0]   digit enable per digit, 0 = dark for its slot
//   upd_req         level request to load value/dp/en at the next frame boundary
//   upd_ack         one-cycle pulse marking a completed shadow load
interface ssd_scan_ctrl_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        upd_req;
    logic        upd_ack;

    modport master (output value, dp, en, upd_req, input  upd_ack);
    modport slave  (input  value, dp, en, upd_req, output upd_ack);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Four-digit seven-segment scan controller. Time-shares one active-low
//   segment bus across four common-anode digits, SCAN_DIV cycles per digit
//   slot. Phase 0 of each slot is a ghost-guard cycle with everything dark.
//   value/dp/en are copied into shadow registers only on the frame boundary
//   (digit 3 -> 0 wrap) so a frame never shows mixed old/new data.
//
// Ports
//   CLK          system clock, rising edge
//   rst_n        synchronous active-low reset
//   bus          ssd_scan_ctrl_if.slave (value, dp, en, upd_req, upd_ack)
//   ssd_ctl[3:0] digit select, active-low
//   seg[7:0]     {a,b,c,d,e,f,g,dp}, active-low
//
// Optional build macro
//   SSD_LEADING_ZERO_BLANK_EN  darkens leading zero digits 3..1 (digit 0
//                              always shows), judged on shadow contents.
module ssd_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic                CLK,
    input  logic                rst_n,
    ssd_scan_ctrl_if.slave      bus,
    output logic [3:0]          ssd_ctl,
    output logic [7:0]          seg
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] ph, ph_nxt;
    logic [1:0]    idx, idx_nxt;
    logic          wrap, boundary, load;

    logic [15:0]   sh_val;
    logic [3:0]    sh_dp;
    logic [3:0]    sh_en;

    logic [3:0]    nib;
    logic [3:0]    lz_blank;
    logic [3:0]    ctl_nxt;
    logic [7:0]    seg_nxt;

    // Segments a..g, active-low, for one hex digit.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h01;
            4'h1: glyph = 7'h4F;
            4'h2: glyph = 7'h12;
            4'h3: glyph = 7'h06;
            4'h4: glyph = 7'h4C;
            4'h5: glyph = 7'h24;
            4'h6: glyph = 7'h20;
            4'h7: glyph = 7'h0F;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h04;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h60;
            4'hC: glyph = 7'h31;
            4'hD: glyph = 7'h42;
            4'hE: glyph = 7'h30;
            default: glyph = 7'h38;
        endcase
    endfunction

    always_comb begin
        wrap     = (ph == PH_LAST);
        ph_nxt   = wrap ? '0 : ph + PW'(1);
        idx_nxt  = wrap ? idx + 2'd1 : idx;
        boundary = wrap && (idx == 2'd3);
        load     = boundary && bus.upd_req;
    end

    // Outputs are registered from the next phase/index so they line up
    // with the counters. Shadow changes only on the boundary edge, whose
    // next phase is the ghost guard, so using the current shadow is safe.
    always_comb begin
        nib      = sh_val[{idx_nxt, 2'b00} +: 4];
        lz_blank = 4'b0000;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        lz_blank[3] = (sh_val[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (sh_val[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (sh_val[7:4]  == 4'h0);
`endif
        ctl_nxt = 4'b1111;
        seg_nxt = 8'hFF;
        if (ph_nxt != '0 && sh_en[idx_nxt] && !lz_blank[idx_nxt]) begin
            ctl_nxt = ~(4'b0001 << idx_nxt);
            seg_nxt = {glyph(nib), ~sh_dp[idx_nxt]};
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            ph          <= '0;
            idx         <= 2'd0;
            sh_val      <= 16'h0000;
            sh_dp       <= 4'h0;
            sh_en       <= 4'hF;
            ssd_ctl     <= 4'b1111;
            seg         <= 8'hFF;
            bus.upd_ack <= 1'b0;
        end else begin
            ph          <= ph_nxt;
            idx         <= idx_nxt;
            if (load) begin
                sh_val <= bus.value;
                sh_dp  <= bus.dp;
                sh_en  <= bus.en;
            end
            ssd_ctl     <= ctl_nxt;
            seg         <= seg_nxt;
            bus.upd_ack <= load;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
module tb_ssd_scan_ctrl;

    localparam int D = 4;

    typedef struct packed {
        logic [3:0] ctl;
        logic [7:0] seg;
        logic       ack;
    } exp_t;

    logic       CLK;
    logic       rst_n;
    logic [3:0] ssd_ctl;
    logic [7:0] seg;

    ssd_scan_ctrl_if bus ();

    ssd_scan_ctrl #(.SCAN_DIV(D)) dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .bus     (bus),
        .ssd_ctl (ssd_ctl),
        .seg     (seg)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: after each edge, derive expected outputs from the
    // edge count since reset, the spec's glyph table and a model shadow.
    initial begin : model
        logic [7:0]  gly [16];
        int          k;
        logic [15:0] m_val;
        logic [3:0]  m_dp, m_en;
        int          ph, dg;
        logic [3:0]  n;
        logic        blank;
        exp_t        e;
        gly = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
        k = 0; m_val = 16'h0; m_dp = 4'h0; m_en = 4'hF;
        forever begin
            @(posedge CLK);
            e.ctl = 4'b1111; e.seg = 8'hFF; e.ack = 1'b0;
            if (!rst_n) begin
                k = 0; m_val = 16'h0; m_dp = 4'h0; m_en = 4'hF;
            end else begin
                k++;
                if (k % (4 * D) == 0 && bus.upd_req) begin
                    m_val = bus.value; m_dp = bus.dp; m_en = bus.en;
                    e.ack = 1'b1;
                end
                ph = k % D;
                dg = (k / D) % 4;
                n  = 4'((m_val >> (4 * dg)) & 16'hF);
                blank = 1'b0;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank = (dg != 0) && ((m_val >> (4 * dg)) == 16'h0);
`endif
                if (ph != 0 && m_en[dg] && !blank) begin
                    e.ctl = 4'b1111;
                    e.ctl[dg] = 1'b0;
                    e.seg = gly[n];
                    e.seg[0] = ~m_dp[dg];
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the queued expectation.
    initial begin : monitor
        exp_t e;
        logic prev_ack;
        prev_ack = 1'b0;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (ssd_ctl !== e.ctl || seg !== e.seg || bus.upd_ack !== e.ack) begin
                    bad++;
                    $display("FAIL outputs @%0t: ctl=%b exp=%b seg=%h exp=%h ack=%b exp=%b",
                             $time, ssd_ctl, e.ctl, seg, e.seg, bus.upd_ack, e.ack);
                end
                if (prev_ack) begin
                    total++;
                    if (bus.upd_ack !== 1'b0) begin
                        bad++;
                        $display("FAIL ack_twice @%0t: ack=%b exp=0", $time, bus.upd_ack);
                    end
                end
                prev_ack = bus.upd_ack;
            end
        end
    end

    task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        bit got;
        got = 1'b0;
        bus.value = v; bus.dp = d; bus.en = e; bus.upd_req = 1'b1;
        for (int i = 0; i < 6 * D * 4 && !got; i++) begin
            @(negedge CLK);
            if (bus.upd_ack === 1'b1) got = 1'b1;
        end
        bus.upd_req = 1'b0;
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: ack=0 exp=1 within %0d cycles", 6 * D * 4);
        end
    endtask

    initial begin : stim
        logic [15:0] v;
        rst_n = 1'b0;
        bus.value = 16'h0; bus.dp = 4'h0; bus.en = 4'hF; bus.upd_req = 1'b0;
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        repeat (6) @(negedge CLK);
        load(16'h1A2F, 4'b0100, 4'hF);
        repeat (16) @(negedge CLK);
        load(16'h1A2F, 4'b0000, 4'b1010);
        repeat (16) @(negedge CLK);
        load(16'h0050, 4'b0000, 4'hF);
        repeat (20) @(negedge CLK);
        load(16'h8000, 4'b0001, 4'hF);
        // mid-frame reset during digit 2 with a request pending
        repeat (10) @(negedge CLK);
        bus.value = 16'hBEEF; bus.dp = 4'hF; bus.en = 4'hF; bus.upd_req = 1'b1;
        rst_n = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (8) @(negedge CLK);
        bus.upd_req = 1'b0;
        repeat (20) @(negedge CLK);
        for (int r = 0; r < 10; r++) begin
            v = 16'($urandom);
            if (r % 2 == 1) v = v >> (4 * $urandom_range(1, 3));
            repeat ($urandom_range(0, 20)) @(negedge CLK);
            load(v, 4'($urandom), (r % 3 == 0) ? 4'hF : 4'($urandom));
            repeat ($urandom_range(4, 40)) @(negedge CLK);
        end
        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

endmodule
